// File: rtl/mem_port_arbiter.sv
// Shares one data memory between instruction fetch and the MEM-stage load/store
// port. One grant per cycle; data wins contention unless fetch has been starved
// for STARVE_LIMIT consecutive cycles. Read responses are steered back to the
// right requester by a tag pipeline matching the fixed memory latency.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_stall,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_stall,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]             starve_cnt;
  logic                   starved;
  logic                   rd_gnt;
  logic [MEM_LATENCY-1:0] vld_pipe;
  logic [MEM_LATENCY-1:0] src_pipe;
  logic                   rsp_vld;
  logic                   rsp_src;
  logic [DATA_W-1:0]      i_rdata_q;
  logic [DATA_W-1:0]      d_rdata_q;

  // Grant logic: data has priority unless fetch has hit the starvation limit.
  assign starved = (starve_cnt == LIMIT);
  assign i_gnt   = i_req & (~d_req | starved);
  assign d_gnt   = d_req & ~i_gnt;
  assign i_stall = i_req & ~i_gnt;
  assign d_stall = d_req & ~d_gnt;
  assign rd_gnt  = i_gnt | (d_gnt & ~d_we);

  // Memory port mux: idle cycles drive all zeros; fetch never writes.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (i_gnt) begin
      mem_addr = i_addr;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_we    = d_we;
      mem_wdata = d_wdata;
    end
  end

  // Starvation counter: counts consecutive denied fetch cycles, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 starve_cnt <= '0;
    else if (!i_req || i_gnt) starve_cnt <= '0;
    else if (!starved)        starve_cnt <= starve_cnt + 4'd1;
  end

  // Contention counter for perf debug; sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        conflict_cnt <= '0;
    else if (i_req && d_req && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
  end

  // Response tag pipeline {valid, src}; shifts every cycle, src 1 = data port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      src_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_gnt;
      src_pipe[0] <= d_gnt;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        src_pipe[k] <= src_pipe[k-1];
      end
    end
  end

  assign rsp_vld  = vld_pipe[MEM_LATENCY-1];
  assign rsp_src  = src_pipe[MEM_LATENCY-1];
  assign i_rvalid = rsp_vld & ~rsp_src;
  assign d_rvalid = rsp_vld & rsp_src;

  // Read data passes straight through on a response and otherwise holds the
  // last value delivered to that port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_rvalid) i_rdata_q <= mem_rdata;
      if (d_rvalid) d_rdata_q <= mem_rdata;
    end
  end

  assign i_rdata = i_rvalid ? mem_rdata : i_rdata_q;
  assign d_rdata = d_rvalid ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level reference model:
// arbitration by the priority/starvation rule, responses as a queue of
// (due cycle, port) entries, counters as plain integers.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int LIM = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic          i_gnt, i_stall, i_rvalid, d_gnt, d_stall, d_rvalid, mem_we;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [15:0]   conflict_cnt;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_stall(i_stall),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_stall(d_stall), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  typedef struct { int due; bit src; } rsp_t;
  rsp_t          q[$];
  int            cyc = 0;
  int            m_starve = 0;
  int            m_conf = 0;
  logic [DW-1:0] m_ilast = '0, m_dlast = '0;
  bit            m_ig, m_dg;
  bit            obs_ig, obs_irv, obs_drv;

  // One clock cycle: drive inputs just after posedge, check at negedge,
  // advance the model at the next posedge.
  task automatic step(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dwe,
                      input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                      input logic [DW-1:0] mrd, input bit do_chk);
    bit rv_i, rv_d;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    mem_rdata = mrd;
    @(negedge clk);
    m_ig = ir && (!dr || m_starve == LIM);
    m_dg = dr && !m_ig;
    rv_i = 1'b0; rv_d = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      rv_i = !q[0].src;
      rv_d = q[0].src;
      void'(q.pop_front());
    end
    obs_ig = i_gnt; obs_irv = i_rvalid; obs_drv = d_rvalid;
    if (do_chk) begin
      chk("i_gnt", i_gnt, m_ig);
      chk("d_gnt", d_gnt, m_dg);
      chk("i_stall", i_stall, ir && !m_ig);
      chk("d_stall", d_stall, dr && !m_dg);
      chk("mem_addr", mem_addr, m_ig ? ia : (m_dg ? da : '0));
      chk("mem_we", mem_we, m_dg && dwe);
      chk("mem_wdata", mem_wdata, m_dg ? dwd : '0);
      chk("i_rvalid", i_rvalid, rv_i);
      chk("d_rvalid", d_rvalid, rv_d);
      chk("i_rdata", i_rdata, rv_i ? mrd : m_ilast);
      chk("d_rdata", d_rdata, rv_d ? mrd : m_dlast);
      chk("conflict_cnt", conflict_cnt, m_conf);
    end
    @(posedge clk);
    if (rv_i) m_ilast = mrd;
    if (rv_d) m_dlast = mrd;
    if (ir && !m_ig) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
    else             m_starve = 0;
    if (ir && dr && m_conf < 16'hFFFF) m_conf++;
    if (m_ig || (m_dg && !dwe)) q.push_back('{due: cyc + LAT, src: m_dg});
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, '0, 0, 0, '0, '0, $urandom, 1);
  endtask

  task automatic model_clear();
    q.delete();
    m_starve = 0; m_conf = 0; m_ilast = '0; m_dlast = '0;
  endtask

  // Hold reset for a few cycles with idle inputs; everything must read zero.
  task automatic hold_reset();
    rst = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    model_clear();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_i_rvalid", i_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_gnt", {i_gnt, d_gnt, mem_we}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_conflict", conflict_cnt, 0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  bit            pend_i, pend_d, p_dwe;
  logic [AW-1:0] p_ia, p_da;
  logic [DW-1:0] p_dwd;
  int            n_drv;

  initial begin
    hold_reset();

    // single fetch, memory answers DEADBEEF after the latency
    step(1, 32'h40, 0, 0, '0, '0, $urandom, 1);
    chk("fetch_gnt_same_cycle", obs_ig, 1);
    for (int k = 0; k < LAT; k++) step(0, '0, 0, 0, '0, '0, 32'hDEADBEEF, 1);
    chk("fetch_rsp_at_latency", obs_irv, 1);
    chk("fetch_no_d_rvalid", obs_drv, 0);
    chk("fetch_rdata_hold", i_rdata, 32'hDEADBEEF);

    // store: memory drive only, no responses follow
    step(0, '0, 1, 1, 32'h100, 32'h12345678, $urandom, 1);
    idle(LAT + 1);

    // contention with loads: d,d,d,i,d,d
    for (int k = 0; k < 6; k++) begin
      step(1, 32'h200 + k, 1, 0, 32'h300 + k, '0, $urandom, 1);
      chk("starve_pattern", obs_ig, (k == 3));
    end
    idle(LAT + 1);

    // alternating fetch / load grants, responses in grant order
    for (int k = 0; k < 4; k++)
      step(!k[0], 32'h500 + k, k[0], 0, 32'h600 + k, '0, $urandom, 1);
    idle(LAT + 1);

    // reset one cycle after a load grant: that load must never respond
    step(0, '0, 1, 0, 32'h700, '0, $urandom, 1);
    #1;
    hold_reset();
    n_drv = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      step(0, '0, 0, 0, '0, '0, $urandom, 1);
      if (obs_drv) n_drv++;
    end
    chk("no_rsp_after_reset", n_drv, 0);

    // randomized traffic; requesters hold until granted, may drop
    pend_i = 0; pend_d = 0;
    for (int k = 0; k < 1500; k++) begin
      if (!pend_i || $urandom_range(0, 9) == 0) begin
        pend_i = ($urandom_range(0, 2) != 0);
        p_ia = $urandom;
      end
      if (!pend_d || $urandom_range(0, 9) == 0) begin
        pend_d = ($urandom_range(0, 1) != 0);
        p_dwe = $urandom_range(0, 1);
        p_da = $urandom;
        p_dwd = $urandom;
      end
      step(pend_i, p_ia, pend_d, p_dwe, p_da, p_dwd, $urandom, 1);
      if (m_ig) pend_i = 0;
      if (m_dg) pend_d = 0;
    end
    idle(LAT + 1);

    // long contention run to saturate the counter
    for (int k = 0; k < 70000; k++)
      step(1, $urandom, 1, 0, $urandom, '0, $urandom, 0);
    chk("conflict_saturated", conflict_cnt, 16'hFFFF);
    step(1, 32'h10, 1, 0, 32'h20, '0, $urandom, 1);
    step(1, 32'h14, 1, 1, 32'h24, 32'h5, $urandom, 1);
    chk("conflict_holds", conflict_cnt, 16'hFFFF);
    idle(LAT + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
